find_z_sequencer: RTL and testbench
===================================

Name: find_z_sequencer

Overview:
- Controller that sequences the single-bit Find_Z combinational datapath over a multi-bit word.
- Latches a WIDTH-bit operand on start.
- Drives each bit, LSB first, onto the datapath's B input and holds it SETTLE cycles.
- Samples the returned Z, assembles the WIDTH-bit result and reports it with a busy/done handshake.
- Sits between the top-level control and one Find_Z instance; the only block that drives that instance's B.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- SETTLE, 1, clock cycles B is held stable before Z is sampled; legal range 1..15; 0 is a compile-time error.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; accepted only when busy=0.
- din  input  WIDTH  operand; captured on the accepting edge.
- b_out  output  1  drives datapath B.
- z_in  input  1  datapath Z return.
- busy  output  1  high while a word is in flight.
- done  output  1  one-cycle pulse; dout valid.
- dout  output  WIDTH  assembled Z word; holds until next done.

Behaviour:
- Reset (async assert, sync deassert by design): state=IDLE, b_out=0, busy=0, done=0, dout=0, internal operand/index/settle counter = 0. Reset mid-word aborts it: no done, dout=0.
- States:
  - IDLE: busy=0. On an edge with start=1:
    - latch din into op_q, idx=0, cnt=0;
    - set b_out=din[0], busy=1;
    - go to RUN.
  - RUN: cnt increments each edge. On the edge where cnt==SETTLE-1:
    - write z_in into res_q[idx] and clear cnt.
    - If idx==WIDTH-1: copy res_q, with the newly sampled bit merged, into dout; set done=1, busy=0; go to IDLE.
    - Otherwise: idx+1, and b_out=op_q[idx+1] on that same edge.
- Timing: accepting edge E0. Bit k is driven from edge E0+k*SETTLE and sampled at edge E0+(k+1)*SETTLE. dout/done update at edge E0+WIDTH*SETTLE, so latency is WIDTH*SETTLE cycles.
- done is high for exactly the one cycle after the final sample edge.
- start during RUN is ignored; din changes during RUN have no effect.
- start high while done=1: accepted (state is IDLE), giving back-to-back words with no gap cycle.
- b_out after completion holds the last driven bit until the next accept or reset.
- Widths:
  - idx is clog2(WIDTH) bits; wrap is impossible because of the explicit idx==WIDTH-1 test.
  - cnt is clog2(SETTLE+1) bits.
- z_in is sampled directly, with no synchronizer; the datapath is same-clock combinational.

Optional Feature:
- Macro FIND_Z_SEQ_ONES_COUNT_EN.
- Defined:
  - adds output ones_cnt, width clog2(WIDTH+1), reset 0;
  - updated on the same edge as dout with the number of 1 bits in the new dout;
  - held otherwise.
- Undefined: port and logic absent; no other behaviour changes.

Decomposition:
- Shared package find_z_pkg:
  - state encoding constants (IDLE=1'b0, RUN=1'b1);
  - WIDTH/SETTLE defaults and legal-range limits;
  - the clog2 helper function.
- One natural sub-module, find_z_settle_cnt: the settle counter with clear/enable, emitting a tick when cnt==SETTLE-1.

Test Plan:
- Reset during RUN: assert rst 3 cycles after start -> b_out, busy, done, dout all 0 immediately; no done pulse afterwards.
- Bench Z=~B model, WIDTH=8, SETTLE=1, din=8'hA5, start for 1 cycle:
  - busy high for 8 cycles;
  - done pulses on cycle 8;
  - dout=8'h5A;
  - b_out sequence 1,0,1,0,0,1,0,1.
- Z=B model, SETTLE=3, din=8'h3C:
  - each b_out value held 3 cycles;
  - done at 24 cycles;
  - dout=8'h3C.
- start re-asserted mid-RUN with din=8'hFF -> ignored; result still reflects the first operand.
- Back-to-back: start held high through done with din=8'h01 then 8'h80 (Z=B) -> second word accepted on the done cycle; dout=8'h01 then 8'h80, 16 cycles total.
- FIND_Z_SEQ_ONES_COUNT_EN defined, Z=B, din=8'hF0 -> ones_cnt=4 on the done cycle; reset returns it to 0.

Source files
------------

// File: rtl/find_z_pkg.sv
// Shared types, limits and helpers for the Find_Z word sequencer.
package find_z_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fz_state_e;

  localparam int unsigned FZ_WIDTH_DEF  = 8;
  localparam int unsigned FZ_WIDTH_MIN  = 2;
  localparam int unsigned FZ_WIDTH_MAX  = 32;
  localparam int unsigned FZ_SETTLE_DEF = 1;
  localparam int unsigned FZ_SETTLE_MIN = 1;
  localparam int unsigned FZ_SETTLE_MAX = 15;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/find_z_settle_cnt.sv
// Settle counter: counts held-B cycles and ticks on the cycle the sample is due.
module find_z_settle_cnt
  import find_z_pkg::*;
#(
  parameter int unsigned SETTLE = FZ_SETTLE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = clog2(SETTLE + 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(SETTLE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/find_z_sequencer.sv
// Sequences a single-bit Find_Z datapath across a WIDTH-bit word, LSB first.
// Optional ones_cnt output enabled by FIND_Z_SEQ_ONES_COUNT_EN.
module find_z_sequencer
  import find_z_pkg::*;
#(
  parameter int unsigned WIDTH  = FZ_WIDTH_DEF,
  parameter int unsigned SETTLE = FZ_SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             b_out,
  input  logic             z_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
`ifdef FIND_Z_SEQ_ONES_COUNT_EN
  ,
  output logic [clog2(WIDTH+1)-1:0] ones_cnt
`endif
);

  localparam int unsigned IW = clog2(WIDTH);

  if (WIDTH < FZ_WIDTH_MIN || WIDTH > FZ_WIDTH_MAX) begin : g_bad_width
    $error("find_z_sequencer: WIDTH out of range");
  end
  if (SETTLE < FZ_SETTLE_MIN || SETTLE > FZ_SETTLE_MAX) begin : g_bad_settle
    $error("find_z_sequencer: SETTLE out of range");
  end

  fz_state_e        state;
  logic [WIDTH-1:0] op_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_nxt;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    idx_nxt;
  logic             accept;
  logic             tick;

  assign accept  = (state == IDLE) && start;
  assign idx_nxt = idx + IW'(1);

  // Result with the bit being sampled this edge already merged in.
  always_comb begin
    res_nxt      = res_q;
    res_nxt[idx] = z_in;
  end

  find_z_settle_cnt #(
    .SETTLE(SETTLE)
  ) u_settle (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (state == RUN),
    .tick(tick)
  );

`ifdef FIND_Z_SEQ_ONES_COUNT_EN
  localparam int unsigned OW = clog2(WIDTH + 1);
  logic [OW-1:0] ones_nxt;

  always_comb begin
    ones_nxt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ones_nxt = ones_nxt + OW'(res_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_cnt <= '0;
    end else if (state == RUN && tick && idx == IW'(WIDTH - 1)) begin
      ones_cnt <= ones_nxt;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
      res_q <= '0;
      idx   <= '0;
      b_out <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dout  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= din;
            idx   <= '0;
            b_out <= din[0];
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (tick) begin
            res_q <= res_nxt;
            if (idx == IW'(WIDTH - 1)) begin
              dout  <= res_nxt;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              idx   <= idx_nxt;
              b_out <= op_q[idx_nxt];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_find_z_sequencer.sv
// Directed bench for find_z_sequencer: SETTLE=1 and SETTLE=3 instances, Z=B or Z=~B model.
module tb_find_z_sequencer;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start0 = 1'b0, start1 = 1'b0;
  logic [W-1:0] din0 = '0, din1 = '0;
  logic         inv0 = 1'b0, inv1 = 1'b0;
  logic         b0, b1, z0, z1, busy0, busy1, done0, done1;
  logic [W-1:0] dout0, dout1;
`ifdef FIND_Z_SEQ_ONES_COUNT_EN
  logic [3:0]   ones0, ones1;
`endif

  assign z0 = b0 ^ inv0;
  assign z1 = b1 ^ inv1;

  find_z_sequencer #(.WIDTH(W), .SETTLE(1)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .din(din0), .b_out(b0), .z_in(z0),
    .busy(busy0), .done(done0), .dout(dout0)
`ifdef FIND_Z_SEQ_ONES_COUNT_EN
    , .ones_cnt(ones0)
`endif
  );

  find_z_sequencer #(.WIDTH(W), .SETTLE(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .din(din1), .b_out(b1), .z_in(z1),
    .busy(busy1), .done(done1), .dout(dout1)
`ifdef FIND_Z_SEQ_ONES_COUNT_EN
    , .ones_cnt(ones1)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit           sel;      // 0: SETTLE=1 instance, 1: SETTLE=3 instance
    logic [W-1:0] din;
    bit           inv;      // Z = B ^ inv
    bit           restart;  // pulse start with din=FF mid-word
    logic [W-1:0] exp_dout;
    int           exp_ones;
  } vec_t;

  vec_t vecs[5];

  task automatic drive(input bit sel, input logic s, input logic [W-1:0] d, input logic iv);
    if (sel) begin start1 = s; din1 = d; inv1 = iv; end
    else     begin start0 = s; din0 = d; inv0 = iv; end
  endtask

  task automatic run_word(input vec_t v);
    int s, n, busy_cnt, berr, lim;
    bit got;
    logic bb, by, dn;
    logic [W-1:0] dv;
    logic [3:0] ov;
    s   = v.sel ? 3 : 1;
    lim = W * s + 6;
    n = 0; busy_cnt = 0; berr = 0; got = 0;
    @(negedge clk);
    drive(v.sel, 1'b1, v.din, v.inv);
    while (!got && n < lim) begin
      @(negedge clk);
      n++;
      if (n == 1) drive(v.sel, 1'b0, v.din, v.inv);
      if (v.restart && n == 3) drive(v.sel, 1'b1, 8'hFF, v.inv);
      if (v.restart && n == 4) drive(v.sel, 1'b0, 8'hFF, v.inv);
      bb = v.sel ? b1 : b0;
      by = v.sel ? busy1 : busy0;
      dn = v.sel ? done1 : done0;
      if (dn) got = 1;
      else begin
        if (by) busy_cnt++;
        if (bb !== v.din[(n-1)/s]) berr++;
      end
    end
    dv = v.sel ? dout1 : dout0;
`ifdef FIND_Z_SEQ_ONES_COUNT_EN
    ov = v.sel ? ones1 : ones0;
`else
    ov = 4'(v.exp_ones);
`endif
    chk("latency", 32'(n), 32'(W * s + 1));
    chk("busy_cycles", 32'(busy_cnt), 32'(W * s));
    chk("b_out_seq_errors", 32'(berr), 32'd0);
    chk("dout", 32'(dv), 32'(v.exp_dout));
`ifdef FIND_Z_SEQ_ONES_COUNT_EN
    chk("ones_cnt", 32'(ov), 32'(v.exp_ones));
`endif
    @(negedge clk);
    chk("done_one_cycle", 32'(v.sel ? done1 : done0), 32'd0);
    chk("b_out_hold", 32'(v.sel ? b1 : b0), 32'(v.din[W-1]));
  endtask

  initial begin
    int n, done_seen;
    bit got;

    vecs[0] = '{sel: 0, din: 8'hA5, inv: 1, restart: 0, exp_dout: 8'h5A, exp_ones: 4};
    vecs[1] = '{sel: 1, din: 8'h3C, inv: 0, restart: 0, exp_dout: 8'h3C, exp_ones: 4};
    vecs[2] = '{sel: 0, din: 8'h3C, inv: 0, restart: 1, exp_dout: 8'h3C, exp_ones: 4};
    vecs[3] = '{sel: 1, din: 8'hC3, inv: 1, restart: 1, exp_dout: 8'h3C, exp_ones: 4};
    vecs[4] = '{sel: 0, din: 8'hF0, inv: 0, restart: 0, exp_dout: 8'hF0, exp_ones: 4};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_b_out", 32'(b0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_dout", 32'(dout0), 32'd0);

    for (int i = 0; i < 5; i++) run_word(vecs[i]);

    // Reset three cycles into a word aborts it and clears the previous result.
    @(negedge clk);
    start0 = 1'b1; din0 = 8'hA5; inv0 = 1'b0;
    @(negedge clk);
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_b_out", 32'(b0), 32'd0);
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_done", 32'(done0), 32'd0);
    chk("midrst_dout", 32'(dout0), 32'd0);
`ifdef FIND_Z_SEQ_ONES_COUNT_EN
    chk("midrst_ones", 32'(ones0), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done0 || busy0) done_seen++;
    end
    chk("no_done_after_rst", 32'(done_seen), 32'd0);

    // Back-to-back: start held through done, second word taken on the done cycle.
    @(negedge clk);
    start0 = 1'b1; din0 = 8'h01; inv0 = 1'b0;
    n = 0; got = 0;
    while (!got && n < 14) begin
      @(negedge clk); n++;
      if (done0) got = 1;
    end
    chk("b2b_first_latency", 32'(n), 32'd9);
    chk("b2b_first_dout", 32'(dout0), 32'h01);
    din0 = 8'h80;
    @(negedge clk); n++;
    chk("b2b_busy_no_gap", 32'(busy0), 32'd1);
    chk("b2b_first_bit", 32'(b0), 32'd0);
    start0 = 1'b0;
    got = 0;
    while (!got && n < 24) begin
      @(negedge clk); n++;
      if (done0) got = 1;
    end
    chk("b2b_second_latency", 32'(n), 32'd18);
    chk("b2b_second_dout", 32'(dout0), 32'h80);
`ifdef FIND_Z_SEQ_ONES_COUNT_EN
    chk("b2b_ones", 32'(ones0), 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
